stream_src: RTL and testbench
=============================

STREAM_SRC -- requirements
Module: stream_src

Interface
REQ-001 SHALL have parameter N_LANES, default 4, number of kernel input streams.
REQ-002 SHALL have parameter DATA_W, default 32, stream word width.
REQ-003 SHALL have parameter WORDS_PER_EXE, default 1024, words per lane per execution (1..65535).
REQ-004 SHALL have parameter NUM_EXE, default 2, executions to run (1..63).
REQ-005 SHALL have parameter PATTERN, default 0: 0 = counter words, 1 = LFSR words.
REQ-006 SHALL have port ap_clk  in  1  sole clock; all logic is rising-edge.
REQ-007 SHALL have port ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port en  in  1  level; high permits new executions.
REQ-009 SHALL have port ap_start  out  1  kernel start.
REQ-010 SHALL have port ap_ready  in  1  kernel accepted start.
REQ-011 SHALL have port ap_done  in  1  kernel finished one execution.
REQ-012 SHALL have port D_in_dout  out  N_LANES*DATA_W  lane k word at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port D_in_empty_n  out  N_LANES  per-lane word-available (ap_fifo read side).
REQ-014 SHALL have port D_in_read  in  N_LANES  per-lane kernel pop.
REQ-015 SHALL have port exe_cnt  out  6  completed executions.
REQ-016 SHALL have port all_done  out  1  NUM_EXE executions completed.
REQ-017 SHALL have port underrun_err  out  N_LANES  sticky: read while empty.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD -> START -> RUN -> (LOAD | FIN).
REQ-019 IDLE SHALL go to LOAD when en=1 and exe_cnt<NUM_EXE.
REQ-020 LOAD (one cycle) SHALL reset every lane's word index to 0 and reload its generator, discarding residual words.
REQ-021 START SHALL hold ap_start=1 until ap_ready=1, then go to RUN; ap_start SHALL be 0 in every other state.
REQ-022 RUN SHALL, on ap_done=1, increment exe_cnt and go to FIN if exe_cnt+1=NUM_EXE, else LOAD if en=1, else IDLE.
REQ-023 ap_ready and ap_done in the same START cycle SHALL be treated as ready then done (counts one execution).
REQ-024 FIN SHALL hold all_done=1 and be exited only by reset.
REQ-025 Lane k SHALL assert D_in_empty_n[k] from the cycle after LOAD until WORDS_PER_EXE words have been popped in this execution.
REQ-026 A pop SHALL be D_in_read[k]=1 with D_in_empty_n[k]=1; the next word SHALL appear on dout the following cycle (zero-bubble streaming, one pop per cycle).
REQ-027 Pop of the last word SHALL drop empty_n[k] the following cycle.
REQ-028 D_in_read[k]=1 with empty_n[k]=0 SHALL be ignored for data and SHALL set underrun_err[k].
REQ-029 PATTERN=0 word SHALL be {k[7:0], exe_cnt zero-extended to 8 bits, index[15:0]}, zero-extended or truncated (LSBs kept) to DATA_W.
REQ-030 PATTERN=1 word SHALL be a 32-bit Galois LFSR, taps 0x80200003, seed 0xACE1_0000+k, stepped per pop, truncated/zero-extended to DATA_W.
REQ-031 Every execution SHALL present identical LFSR sequences (reseeded in LOAD).
REQ-032 en falling during START/RUN SHALL not abort; the current execution completes.

Reset
REQ-033 ap_rst_n=0 SHALL asynchronously force state IDLE, ap_start=0, D_in_empty_n=0, D_in_dout=0, exe_cnt=0, all_done=0, underrun_err=0, indices 0.
REQ-034 Reset mid-execution SHALL discard all lane state; no word is re-presented until a new LOAD.

Structure
REQ-035 Package stream_src_pkg SHALL hold the FSM state enum, LFSR taps and seed base constants.
REQ-036 Per-lane logic SHALL be sub-module stream_src_lane, instantiated N_LANES times.

Verification
REQ-037 Defaults, PATTERN=0, kernel model pops every cycle -> lane 2 word 5 of execution 1 = 0x02010005; 1024 words/lane; empty_n low next cycle after last pop.
REQ-038 Kernel holds ap_ready low 7 cycles -> ap_start high exactly 8 cycles, then low.
REQ-039 Random read gaps, PATTERN=1 -> lane 0 first word 0xACE10000; both executions produce identical lane streams.
REQ-040 Read on lane 3 while empty -> underrun_err=4'b1000, stays set; data unaffected.
REQ-041 Two ap_done pulses -> exe_cnt=2, all_done=1, no third ap_start; en dropped mid-RUN -> execution completes, state IDLE, exe_cnt incremented.
REQ-042 ap_rst_n low mid-RUN -> same cycle ap_start=0, empty_n=0, exe_cnt=0.

Source files
------------

// File: rtl/stream_src_pkg.sv
// Shared types and constants for the stream_src test-pattern generator.
// Holds the FSM state encoding and the LFSR step used by every lane.
package stream_src_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_BASE = 32'hACE1_0000;

  // Right-shifting Galois form: bit 0 falling out feeds the tap mask back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/stream_src_lane.sv
// One ap_fifo-style read lane: presents a generated word stream of
// WORDS_PER_EXE words per execution, restarted by a one-cycle load.
module stream_src_lane
  import stream_src_pkg::*;
#(
  parameter int LANE_ID       = 0,
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_EXE = 1024,
  parameter int PATTERN       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [5:0]        exe_cnt,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              empty_n,
  output logic              underrun_err
);

  localparam logic [31:0] SEED = LFSR_SEED_BASE + 32'(LANE_ID);
  localparam logic [15:0] LAST = 16'(WORDS_PER_EXE - 1);

  function automatic logic [DATA_W-1:0] make_word(input logic [5:0]  exe,
                                                  input logic [15:0] idx,
                                                  input logic [31:0] lfsr);
    logic [31:0] raw;
    if (PATTERN == 1) raw = lfsr;
    else              raw = {8'(LANE_ID), 2'b00, exe, idx};
    return DATA_W'(raw);
  endfunction

  logic [15:0]       idx_q, idx_d, idx_nxt;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic [5:0]        exe_q, exe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              empty_n_q, empty_n_d;
  logic              underrun_q, underrun_d;
  logic              pop;

  // The next word is prepared at pop time so dout is always a registered value.
  always_comb begin
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    exe_d      = exe_q;
    dout_d     = dout_q;
    empty_n_d  = empty_n_q;
    underrun_d = underrun_q | (read & ~empty_n_q);
    pop        = read & empty_n_q;
    idx_nxt    = idx_q + 16'd1;
    lfsr_nxt   = lfsr_step(lfsr_q);
    if (load) begin
      idx_d     = 16'd0;
      lfsr_d    = SEED;
      exe_d     = exe_cnt;
      empty_n_d = 1'b1;
      dout_d    = make_word(exe_cnt, 16'd0, SEED);
    end else if (pop) begin
      idx_d     = idx_nxt;
      lfsr_d    = lfsr_nxt;
      empty_n_d = (idx_q != LAST);
      dout_d    = make_word(exe_q, idx_nxt, lfsr_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      lfsr_q     <= '0;
      exe_q      <= '0;
      dout_q     <= '0;
      empty_n_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      exe_q      <= exe_d;
      dout_q     <= dout_d;
      empty_n_q  <= empty_n_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout         = dout_q;
  assign empty_n      = empty_n_q;
  assign underrun_err = underrun_q;

endmodule

// File: rtl/stream_src.sv
// Drives an HLS kernel's ap_ctrl handshake for NUM_EXE executions and feeds
// its N_LANES ap_fifo inputs with counter or LFSR test words.
module stream_src
  import stream_src_pkg::*;
#(
  parameter int N_LANES       = 4,
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_EXE = 1024,
  parameter int NUM_EXE       = 2,
  parameter int PATTERN       = 0
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      en,
  output logic                      ap_start,
  input  logic                      ap_ready,
  input  logic                      ap_done,
  output logic [N_LANES*DATA_W-1:0] D_in_dout,
  output logic [N_LANES-1:0]        D_in_empty_n,
  input  logic [N_LANES-1:0]        D_in_read,
  output logic [5:0]                exe_cnt,
  output logic                      all_done,
  output logic [N_LANES-1:0]        underrun_err
);

  localparam logic [5:0] LAST_EXE = 6'(NUM_EXE);

  state_t     state_q, state_d;
  logic       ap_start_q, ap_start_d;
  logic [5:0] exe_cnt_q, exe_cnt_d;
  logic       all_done_q, all_done_d;
  logic       finish_exe;
  logic       load;

  // A done seen together with ready in START closes the execution immediately.
  always_comb begin
    state_d    = state_q;
    exe_cnt_d  = exe_cnt_q;
    all_done_d = all_done_q;
    finish_exe = 1'b0;
    case (state_q)
      S_IDLE:  if (en && (exe_cnt_q < LAST_EXE)) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (ap_ready) begin
                 state_d    = S_RUN;
                 finish_exe = ap_done;
               end
      S_RUN:   finish_exe = ap_done;
      S_FIN:   state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
    if (finish_exe) begin
      exe_cnt_d = exe_cnt_q + 6'd1;
      if (exe_cnt_q + 6'd1 == LAST_EXE) begin
        state_d    = S_FIN;
        all_done_d = 1'b1;
      end else if (en) begin
        state_d = S_LOAD;
      end else begin
        state_d = S_IDLE;
      end
    end
    ap_start_d = (state_d == S_START);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      ap_start_q <= 1'b0;
      exe_cnt_q  <= '0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start_d;
      exe_cnt_q  <= exe_cnt_d;
      all_done_q <= all_done_d;
    end
  end

  assign load     = (state_q == S_LOAD);
  assign ap_start = ap_start_q;
  assign exe_cnt  = exe_cnt_q;
  assign all_done = all_done_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    stream_src_lane #(
      .LANE_ID      (k),
      .DATA_W       (DATA_W),
      .WORDS_PER_EXE(WORDS_PER_EXE),
      .PATTERN      (PATTERN)
    ) u_lane (
      .clk         (ap_clk),
      .rst_n       (ap_rst_n),
      .load        (load),
      .exe_cnt     (exe_cnt_q),
      .read        (D_in_read[k]),
      .dout        (D_in_dout[k*DATA_W +: DATA_W]),
      .empty_n     (D_in_empty_n[k]),
      .underrun_err(underrun_err[k])
    );
  end

endmodule

// File: tb/tb_stream_src.sv
// Random-stimulus bench for stream_src: a counter-pattern and an LFSR-pattern
// instance run against a cycle-level behavioural model of executions and lanes.
module tb_stream_src;

  localparam int NW = 1024;

  logic         ap_clk;
  logic         ap_rst_n;
  logic         en       [2];
  logic         ap_start [2];
  logic         ap_ready [2];
  logic         ap_done  [2];
  logic [127:0] dout     [2];
  logic [3:0]   empty_n  [2];
  logic [3:0]   rd       [2];
  logic [5:0]   exe_cnt  [2];
  logic         all_done [2];
  logic [3:0]   uerr     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stream_src #(.PATTERN(g)) dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .en          (en[g]),
      .ap_start    (ap_start[g]),
      .ap_ready    (ap_ready[g]),
      .ap_done     (ap_done[g]),
      .D_in_dout   (dout[g]),
      .D_in_empty_n(empty_n[g]),
      .D_in_read   (rd[g]),
      .exe_cnt     (exe_cnt[g]),
      .all_done    (all_done[g]),
      .underrun_err(uerr[g])
    );
  end

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference words: lane k, execution e, word index i.
  logic [31:0] lfsr_tab [4][NW];

  function automatic logic [31:0] exp_word(input int d, input int k, input int e, input int i);
    logic [31:0] w;
    if (d == 0) w = {k[7:0], 2'b00, e[5:0], i[15:0]};
    else        w = lfsr_tab[k][i];
    return w;
  endfunction

  // Behavioural model: executions counted, lanes hold a pop index per load.
  int         m_cnt   [2];
  bit         m_fin   [2];
  bit         m_start [2];
  bit         m_inexe [2];
  bit         m_pend  [2];
  bit         m_valid [2];
  int         m_tag   [2];
  int         m_idx   [2][4];
  logic [3:0] m_uerr  [2];

  logic [31:0] rec     [2][2][4][NW];
  int          rec_cnt [2][2][4];
  bit          rec_on = 1'b1;
  int          run0 = 0;
  int          first_len = 0;

  task automatic model_reset(input int d);
    m_cnt[d] = 0; m_fin[d] = 0; m_start[d] = 0; m_inexe[d] = 0;
    m_pend[d] = 0; m_valid[d] = 0; m_tag[d] = 0; m_uerr[d] = '0;
    for (int k = 0; k < 4; k++) m_idx[d][k] = 0;
  endtask

  task automatic model_finish(input int d);
    m_cnt[d]++;
    m_inexe[d] = 0;
    if (m_cnt[d] == 2) m_fin[d] = 1;
    else if (en[d])    m_pend[d] = 1;
  endtask

  task automatic model_advance(input int d);
    for (int k = 0; k < 4; k++) begin
      if (rd[d][k]) begin
        if (m_valid[d] && m_idx[d][k] < NW) m_idx[d][k]++;
        else m_uerr[d][k] = 1'b1;
      end
    end
    if (m_fin[d]) begin
    end else if (m_start[d]) begin
      if (ap_ready[d]) begin
        m_start[d] = 0;
        m_inexe[d] = 1;
        if (ap_done[d]) model_finish(d);
      end
    end else if (m_inexe[d]) begin
      if (ap_done[d]) model_finish(d);
    end else if (m_pend[d]) begin
      m_pend[d]  = 0;
      m_start[d] = 1;
      m_valid[d] = 1;
      m_tag[d]   = m_cnt[d];
      for (int k = 0; k < 4; k++) m_idx[d][k] = 0;
    end else if (en[d] && m_cnt[d] < 2) begin
      m_pend[d] = 1;
    end
  endtask

  always @(negedge ap_clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0]  ee;
      logic [31:0] a, e;
      bit          any;
      if (!ap_rst_n) model_reset(d);
      any = 0; a = '0; e = '0;
      for (int k = 0; k < 4; k++) begin
        ee[k] = m_valid[d] && (m_idx[d][k] < NW);
        if (ee[k]) begin
          if (!any || a == e) begin
            a = dout[d][k*32 +: 32];
            e = exp_word(d, k, m_tag[d], m_idx[d][k]);
          end
          any = 1;
          if (rd[d][k] && rec_on && ap_rst_n) begin
            rec[d][m_tag[d]][k][m_idx[d][k]] = dout[d][k*32 +: 32];
            rec_cnt[d][m_tag[d]][k]++;
          end
        end
      end
      checkOutput($sformatf("d%0d_ap_start", d), 32'(ap_start[d]), 32'(m_start[d]));
      checkOutput($sformatf("d%0d_empty_n", d), 32'(empty_n[d]), 32'(ee));
      checkOutput($sformatf("d%0d_exe_cnt", d), 32'(exe_cnt[d]), 32'(m_cnt[d]));
      checkOutput($sformatf("d%0d_all_done", d), 32'(all_done[d]), 32'(m_fin[d]));
      checkOutput($sformatf("d%0d_underrun", d), 32'(uerr[d]), 32'(m_uerr[d]));
      if (any) checkOutput($sformatf("d%0d_dout", d), a, e);
      if (ap_rst_n) model_advance(d);
    end
    if (ap_start[0]) run0++;
    else if (run0 > 0) begin
      if (first_len == 0) first_len = run0;
      run0 = 0;
    end
  end

  // Kernel behaviour: accept start after a delay, pop while words exist, then done.
  int k_stc    [2];
  int k_delay  [2];
  bit k_inexe  [2];
  bit k_inj    [2];
  int k_pops   [2][4];
  bit phase_a = 1'b0;
  int en_low  = 0;

  task automatic kernel_clear(input int d);
    k_stc[d] = 0; k_inexe[d] = 0; k_inj[d] = 0;
    for (int k = 0; k < 4; k++) k_pops[d][k] = 0;
  endtask

  task automatic applyStimulus();
    for (int d = 0; d < 2; d++) begin
      bit drained;
      ap_done[d] = 1'b0; ap_ready[d] = 1'b0; rd[d] = '0;
      if (!ap_rst_n) begin
        kernel_clear(d);
        continue;
      end
      drained = 1;
      for (int k = 0; k < 4; k++) if (k_pops[d][k] != NW) drained = 0;
      if (ap_start[d] && !k_inexe[d]) begin
        if (k_stc[d] >= k_delay[d]) begin
          ap_ready[d] = 1'b1;
          k_inexe[d]  = 1;
          k_inj[d]    = (d == 0) && (exe_cnt[d] == 6'd0);
          for (int k = 0; k < 4; k++) k_pops[d][k] = 0;
          k_delay[d]  = int'($urandom_range(0, 3));
          k_stc[d]    = 0;
        end else begin
          k_stc[d]++;
        end
      end else if (k_inexe[d]) begin
        if (drained && !k_inj[d]) begin
          ap_done[d] = 1'b1;
          k_inexe[d] = 0;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (empty_n[d][k] && (d == 0 || $urandom_range(0, 3) != 0)) begin
              rd[d][k] = 1'b1;
              k_pops[d][k]++;
            end
          end
          if (k_inj[d] && k_pops[d][3] == NW && !empty_n[d][3]) begin
            rd[d][3] = 1'b1;
            k_inj[d] = 0;
          end
        end
      end
    end
    if (phase_a) begin
      if (k_inexe[0] && exe_cnt[0] == 6'd0 && k_pops[0][0] >= 500) en[0] = 1'b0;
      if (!en[0] && exe_cnt[0] == 6'd1) begin
        en_low++;
        if (en_low == 20) begin
          checkOutput("idle_exe_cnt", 32'(exe_cnt[0]), 1);
          checkOutput("idle_no_start", 32'(ap_start[0]), 0);
          en[0] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge ap_clk);
    #1;
    applyStimulus();
  endtask

  initial begin
    int diffs;
    int c;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] s;
      s = 32'hACE1_0000 + 32'(k);
      for (int i = 0; i < NW; i++) begin
        lfsr_tab[k][i] = s;
        s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
      end
    end
    ap_rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; ap_ready[d] = 1'b0; ap_done[d] = 1'b0; rd[d] = '0;
      kernel_clear(d);
    end
    k_delay[0] = 7;
    k_delay[1] = 2;
    repeat (3) @(posedge ap_clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_d%0d_start", d), 32'(ap_start[d]), 0);
      checkOutput($sformatf("rst_d%0d_empty", d), 32'(empty_n[d]), 0);
      checkOutput($sformatf("rst_d%0d_dout", d), 32'(dout[d] != '0), 0);
      checkOutput($sformatf("rst_d%0d_cnt", d), 32'(exe_cnt[d]), 0);
    end
    ap_rst_n = 1'b1;
    en[0] = 1'b1;
    en[1] = 1'b1;
    phase_a = 1'b1;

    for (c = 0; c < 30000 && !(all_done[0] && all_done[1]); c++) cycle();
    checkOutput("run_timeout", 32'(all_done[0] & all_done[1]), 1);
    repeat (30) cycle();
    phase_a = 1'b0;

    checkOutput("d0_final_cnt", 32'(exe_cnt[0]), 2);
    checkOutput("d1_final_cnt", 32'(exe_cnt[1]), 2);
    checkOutput("d0_final_done", 32'(all_done[0]), 1);
    checkOutput("d0_underrun_lane3", 32'(uerr[0]), 32'h8);
    checkOutput("d1_no_underrun", 32'(uerr[1]), 0);
    checkOutput("start_pulse_len", 32'(first_len), 8);
    checkOutput("d0_e1_l2_w5", rec[0][1][2][5], 32'h0201_0005);
    checkOutput("d0_e1_l3_last", rec[0][1][3][NW-1], 32'h0301_03FF);
    checkOutput("d0_e0_l2_count", 32'(rec_cnt[0][0][2]), NW);
    checkOutput("d1_e1_l1_count", 32'(rec_cnt[1][1][1]), NW);
    checkOutput("d1_e0_l0_first", rec[1][0][0][0], 32'hACE1_0000);
    checkOutput("d1_e1_l0_first", rec[1][1][0][0], 32'hACE1_0000);
    diffs = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NW; i++)
        if (rec[1][0][k][i] !== rec[1][1][k][i]) diffs++;
    checkOutput("lfsr_repeat_diffs", 32'(diffs), 0);

    // Fresh run, then pull reset in the middle of the second execution.
    rec_on = 1'b0;
    cycle();
    ap_rst_n = 1'b0;
    repeat (2) cycle();
    ap_rst_n = 1'b1;
    for (c = 0; c < 5000 && !(exe_cnt[0] == 6'd1 && k_inexe[0] && k_pops[0][0] >= 10); c++) cycle();
    checkOutput("midrun_reach", 32'(exe_cnt[0] == 6'd1 && k_inexe[0]), 1);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async_rst_start", 32'(ap_start[0]), 0);
    checkOutput("async_rst_empty", 32'(empty_n[0]), 0);
    checkOutput("async_rst_cnt", 32'(exe_cnt[0]), 0);
    checkOutput("async_rst_dout", 32'(dout[0] != '0), 0);
    repeat (3) cycle();
    en[0] = 1'b0;
    en[1] = 1'b0;
    ap_rst_n = 1'b1;
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
